tri_hit_sched: RTL and testbench
================================

TRI_HIT_SCHED -- requirements
Module: tri_hit_sched

Interface
REQ-001 Parameter IDX_W, default 10, triangle index width (max 2^IDX_W triangles).
REQ-002 Parameter T_W, default 32, width of signed fixed-point hit distance (Q_BITS = 10 fraction bits).
REQ-003 Parameter MAX_OUT, default 8, maximum triangles in flight in the hit-test datapath.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  begin a scan; sampled only in IDLE.
REQ-007 tri_count  input  IDX_W+1  number of triangles to scan; sampled with start.
REQ-008 busy  output  1  high in any state other than IDLE.
REQ-009 iss_valid  output  1  issue request to the hit-test datapath.
REQ-010 iss_ready  input  1  datapath accepts the issue when iss_valid && iss_ready.
REQ-011 iss_idx  output  IDX_W  triangle index being issued.
REQ-012 res_valid  input  1  one result per issued triangle, in issue order, no backpressure.
REQ-013 res_hit  input  1  triangle hit boolean (all three edge dot products > 0).
REQ-014 res_t  input  T_W  signed ray distance for the hit.
REQ-015 res_idx  input  IDX_W  index of the result.
REQ-016 done  output  1  one-cycle pulse at scan completion.
REQ-017 hit_any, hit_idx (IDX_W), hit_t (T_W)  outputs  scan result: hit found, nearest index, nearest distance.

Function
REQ-018 FSM states IDLE, ISSUE, DRAIN, DONE; reset state IDLE.
REQ-019 IDLE: start with tri_count==0 -> DONE; start with tri_count>0 -> ISSUE; on accepted start, clear hit_any/hit_idx/hit_t to 0 and zero the issue index.
REQ-020 ISSUE: iss_valid high iff outstanding < MAX_OUT; iss_idx = current index, held stable while iss_valid && !iss_ready.
REQ-021 Each handshake increments the index; handshake on index tri_count-1 -> DRAIN.
REQ-022 Outstanding counter: +1 per issue, -1 per res_valid; simultaneous issue and result leave it unchanged; never exceeds MAX_OUT.
REQ-023 DRAIN: iss_valid low; outstanding==0 -> DONE.
REQ-024 DONE: done=1 for exactly one cycle -> IDLE; hit outputs hold until next accepted start.
REQ-025 Result update on res_valid when res_hit && res_t > 0 && (!hit_any || res_t < hit_t): hit_any=1, hit_idx=res_idx, hit_t=res_t.
REQ-026 Ties (res_t == hit_t) keep the earlier index; res_t <= 0 never counts as a hit.
REQ-027 res_valid with outstanding==0 is ignored (no counter underflow, no result update).
REQ-028 start while busy is ignored; tri_count changes during a scan have no effect.
REQ-029 Latency: tri_count=N, iss_ready=1, datapath latency L -> done exactly N+L+1 cycles after start cycle (N <= MAX_OUT or L < MAX_OUT).

Reset
REQ-030 rst forces IDLE, busy=0, iss_valid=0, done=0, hit_any=0, hit_idx=0, hit_t=0, outstanding=0, index=0.
REQ-031 rst mid-scan abandons the scan with no done pulse; late results afterward are ignored per REQ-027.

Configuration
REQ-032 Macro TRI_HIT_SCHED_ANY_HIT_EN: defined -> input any_hit (1 bit) exists, sampled with start; when latched 1, the first qualifying hit (REQ-025) stops issuing, FSM -> DRAIN, later results ignored for update; undefined -> port absent, closest-hit behaviour only.

Verification
REQ-033 tri_count=4, iss_ready=1, L=3, hits t=5.0,2.0,3.0,miss -> done 8 cycles after start, hit_any=1, hit_idx=1, hit_t=2.0 (0x800).
REQ-034 start with tri_count=0 -> done 2 cycles later, busy high 1 cycle, hit_any=0.
REQ-035 tri_count=20, MAX_OUT=8, L=12, iss_ready=1 -> iss_valid drops at outstanding=8, outstanding never >8, 20 results consumed, done once.
REQ-036 iss_ready toggling 1/0 every cycle, equal t=1.0 on idx 3 and 7 -> iss_idx stable while stalled, hit_idx=3.
REQ-037 rst asserted during ISSUE at index 5, then stray res_valid -> all outputs 0, no done, state IDLE, new start scans normally.
REQ-038 TRI_HIT_SCHED_ANY_HIT_EN defined, any_hit=1, tri_count=16, first hit at idx 2 -> no issue after result 2 seen, done after drain, hit_idx=2.

Source files
------------

// File: rtl/tri_hit_sched.sv
// Triangle hit scheduler: issues indices 0..tri_count-1 to a hit-test datapath and keeps the nearest positive hit.
// Define TRI_HIT_SCHED_ANY_HIT_EN to add the any_hit input (stop issuing at the first qualifying hit).
module tri_hit_sched #(
  parameter int IDX_W   = 10,
  parameter int T_W     = 32,
  parameter int MAX_OUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W:0]   tri_count,
`ifdef TRI_HIT_SCHED_ANY_HIT_EN
  input  logic             any_hit,
`endif
  output logic             busy,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [IDX_W-1:0] iss_idx,
  input  logic             res_valid,
  input  logic             res_hit,
  input  logic [T_W-1:0]   res_t,
  input  logic [IDX_W-1:0] res_idx,
  output logic             done,
  output logic             hit_any,
  output logic [IDX_W-1:0] hit_idx,
  output logic [T_W-1:0]   hit_t
);
  localparam int OUT_W = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   cnt;
  logic [OUT_W-1:0] outstanding, out_nxt;
  logic             any_mode;
  logic             fire, res_ok, t_pos, t_lt, upd, last;

  assign busy      = state != IDLE;
  assign iss_valid = (state == ISSUE) && (outstanding < OUT_W'(MAX_OUT));
  assign iss_idx   = idx;
  assign fire      = iss_valid && iss_ready;
  // A result with nothing in flight is stale (e.g. from before a reset) and is dropped.
  assign res_ok    = res_valid && (outstanding != '0);
  assign last      = {1'b0, idx} == (cnt - (IDX_W+1)'(1));
  assign out_nxt   = outstanding + OUT_W'(fire) - OUT_W'(res_ok);

  assign t_pos = !res_t[T_W-1] && (res_t != '0);
  assign t_lt  = $signed(res_t) < $signed(hit_t);
  // Strict less-than keeps the earlier index on ties; in any-hit mode only the first hit lands.
  assign upd   = res_ok && res_hit && t_pos && (!hit_any || t_lt) && !(any_mode && hit_any);

`ifdef TRI_HIT_SCHED_ANY_HIT_EN
  always_ff @(posedge clk) begin
    if (rst)                        any_mode <= 1'b0;
    else if (state == IDLE && start) any_mode <= any_hit;
  end
`else
  assign any_mode = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      outstanding <= '0;
      done        <= 1'b0;
      hit_any     <= 1'b0;
      hit_idx     <= '0;
      hit_t       <= '0;
    end else begin
      done        <= state == DONE;
      outstanding <= out_nxt;
      if (upd) begin
        hit_any <= 1'b1;
        hit_idx <= res_idx;
        hit_t   <= res_t;
      end
      case (state)
        IDLE: if (start) begin
          cnt     <= tri_count;
          idx     <= '0;
          hit_any <= 1'b0;
          hit_idx <= '0;
          hit_t   <= '0;
          state   <= (tri_count == '0) ? DONE : ISSUE;
        end
        ISSUE: begin
          if (fire) idx <= idx + IDX_W'(1);
          if (upd && any_mode)  state <= DRAIN;
          else if (fire && last) state <= DRAIN;
        end
        DRAIN: if (out_nxt == '0) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tri_hit_sched.sv
// Directed bench for tri_hit_sched; the datapath model returns each result in order,
// presented lat-1 cycles after its issue cycle (latency lat counting the issue cycle).
module tb_tri_hit_sched;
  localparam int MAX_OUT = 8;

  logic        clk = 1'b0;
  logic        rst, start, iss_ready, res_valid, res_hit;
  logic [10:0] tri_count;
  logic [9:0]  res_idx, iss_idx, hit_idx;
  logic [31:0] res_t, hit_t;
  logic        busy, iss_valid, done, hit_any;
`ifdef TRI_HIT_SCHED_ANY_HIT_EN
  logic        any_hit;
`endif

  tri_hit_sched #(.IDX_W(10), .T_W(32), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .start(start), .tri_count(tri_count),
`ifdef TRI_HIT_SCHED_ANY_HIT_EN
    .any_hit(any_hit),
`endif
    .busy(busy), .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_idx(iss_idx),
    .res_valid(res_valid), .res_hit(res_hit), .res_t(res_t), .res_idx(res_idx),
    .done(done), .hit_any(hit_any), .hit_idx(hit_idx), .hit_t(hit_t)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int idx; } ent_t;
  ent_t q[$];

  int checks = 0, failures = 0;
  bit          hit_tab [0:1023];
  logic [31:0] t_tab   [0:1023];
  int done_cyc, done_cnt, busy_cyc, n_res, fires, v_valid, v_order, v_stable, cap_hits;
  bit aborted;

  task automatic clear_tab();
    for (int i = 0; i < 1024; i++) begin hit_tab[i] = 1'b0; t_tab[i] = 32'h400; end
  endtask

  // Runs one scan; abort_idx >= 0 asserts rst when that index is on offer; poke re-pulses start while busy.
  task automatic scan(input int n, input int lat, input bit stall, input bit anyh, input int abort_idx, input bit poke);
    int first_hit, qs;
    ent_t e;
    bit prev_stall, exp_v;
    logic [9:0] prev_idx;
    q.delete();
    done_cyc = -1; done_cnt = 0; busy_cyc = 0; n_res = 0; fires = 0;
    v_valid = 0; v_order = 0; v_stable = 0; cap_hits = 0; aborted = 0;
    first_hit = -1; prev_stall = 0; prev_idx = '0;
    start = 1'b1; tri_count = 11'(n);
`ifdef TRI_HIT_SCHED_ANY_HIT_EN
    any_hit = anyh;
`endif
    @(posedge clk); #1;
    start = 1'b0; tri_count = 11'h7ff;
`ifdef TRI_HIT_SCHED_ANY_HIT_EN
    any_hit = !anyh;
`endif
    for (int c = 1; c < 600; c++) begin
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (done_cyc >= 0 && c > done_cyc + 2) break;
      if (busy) busy_cyc++;
      qs = q.size();
      exp_v = busy && fires < n && qs < MAX_OUT && !(first_hit >= 0 && c > first_hit);
      if (iss_valid !== exp_v) v_valid++;
      if (busy && fires < n && qs == MAX_OUT) cap_hits++;
      if (prev_stall && iss_idx !== prev_idx) v_stable++;
      if (abort_idx >= 0 && iss_valid && iss_idx == 10'(abort_idx)) begin
        rst = 1'b1; iss_ready = 1'b0; res_valid = 1'b0; aborted = 1'b1;
        break;
      end
      res_valid = 1'b0; res_hit = 1'b0; res_t = '0; res_idx = '0;
      if (qs > 0 && q[0].due == c) begin
        e = q.pop_front();
        res_valid = 1'b1; res_idx = 10'(e.idx); res_hit = hit_tab[e.idx]; res_t = t_tab[e.idx];
        n_res++;
        if (anyh && first_hit < 0 && hit_tab[e.idx] && $signed(t_tab[e.idx]) > 0) first_hit = c;
      end
      iss_ready = stall ? c[0] : 1'b1;
      if (iss_valid && iss_ready) begin
        if (iss_idx !== 10'(fires)) v_order++;
        q.push_back('{c + lat - 1, fires});
        fires++;
      end
      prev_stall = iss_valid && !iss_ready;
      prev_idx   = iss_idx;
      start      = poke && c == 2;
      tri_count  = (poke && c == 2) ? 11'd0 : 11'h7ff;
      @(posedge clk); #1;
    end
    res_valid = 1'b0; iss_ready = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL reset_iss_valid: got %0b expected 0", iss_valid); end
    checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++; if (hit_any !== 1'b0)   begin failures++; $display("FAIL reset_hit_any: got %0b expected 0", hit_any); end
    checks++; if (hit_idx !== 10'd0)  begin failures++; $display("FAIL reset_hit_idx: got %0h expected 0", hit_idx); end
    checks++; if (hit_t !== 32'd0)    begin failures++; $display("FAIL reset_hit_t: got %0h expected 0", hit_t); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    clear_tab();
    hit_tab[0] = 1; t_tab[0] = 32'h1400;
    hit_tab[1] = 1; t_tab[1] = 32'h800;
    hit_tab[2] = 1; t_tab[2] = 32'hc00;
    scan(4, 3, 0, 0, -1, 0);
    checks++; if (done_cyc !== 8)      begin failures++; $display("FAIL basic_latency: got %0d expected 8", done_cyc); end
    checks++; if (done_cnt !== 1)      begin failures++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
    checks++; if (hit_any !== 1'b1)    begin failures++; $display("FAIL basic_hit_any: got %0b expected 1", hit_any); end
    checks++; if (hit_idx !== 10'd1)   begin failures++; $display("FAIL basic_hit_idx: got %0d expected 1", hit_idx); end
    checks++; if (hit_t !== 32'h800)   begin failures++; $display("FAIL basic_hit_t: got %0h expected 800", hit_t); end
    checks++; if (v_valid + v_order !== 0) begin failures++; $display("FAIL basic_issue: got %0d errors expected 0", v_valid + v_order); end
    checks++; if (n_res !== 4)         begin failures++; $display("FAIL basic_results: got %0d expected 4", n_res); end
  endtask

  task automatic test_zero();
    scan(0, 3, 0, 0, -1, 0);
    checks++; if (done_cyc !== 2)    begin failures++; $display("FAIL zero_latency: got %0d expected 2", done_cyc); end
    checks++; if (busy_cyc !== 1)    begin failures++; $display("FAIL zero_busy_cycles: got %0d expected 1", busy_cyc); end
    checks++; if (hit_any !== 1'b0)  begin failures++; $display("FAIL zero_hit_any: got %0b expected 0", hit_any); end
    checks++; if (fires !== 0)       begin failures++; $display("FAIL zero_issues: got %0d expected 0", fires); end
  endtask

  task automatic test_nonpositive();
    clear_tab();
    hit_tab[0] = 1; t_tab[0] = 32'h0;
    hit_tab[1] = 1; t_tab[1] = 32'hffff_fc00;
    t_tab[2] = 32'h100;
    scan(3, 2, 0, 0, -1, 0);
    checks++; if (hit_any !== 1'b0)  begin failures++; $display("FAIL nonpos_hit_any: got %0b expected 0", hit_any); end
    checks++; if (hit_t !== 32'd0)   begin failures++; $display("FAIL nonpos_hit_t: got %0h expected 0", hit_t); end
    checks++; if (done_cyc !== 6)    begin failures++; $display("FAIL nonpos_latency: got %0d expected 6", done_cyc); end
  endtask

  task automatic test_limit();
    clear_tab();
    hit_tab[17] = 1; t_tab[17] = 32'h100;
    hit_tab[9]  = 1; t_tab[9]  = 32'h50;
    scan(20, 12, 0, 0, -1, 0);
    checks++; if (v_valid !== 0)     begin failures++; $display("FAIL limit_iss_valid: got %0d errors expected 0", v_valid); end
    checks++; if (cap_hits == 0)     begin failures++; $display("FAIL limit_cap_reached: got %0d cycles expected >0", cap_hits); end
    checks++; if (fires !== 20)      begin failures++; $display("FAIL limit_issues: got %0d expected 20", fires); end
    checks++; if (n_res !== 20)      begin failures++; $display("FAIL limit_results: got %0d expected 20", n_res); end
    checks++; if (done_cnt !== 1)    begin failures++; $display("FAIL limit_done_count: got %0d expected 1", done_cnt); end
    checks++; if (hit_idx !== 10'd9) begin failures++; $display("FAIL limit_hit_idx: got %0d expected 9", hit_idx); end
    checks++; if (hit_t !== 32'h50)  begin failures++; $display("FAIL limit_hit_t: got %0h expected 50", hit_t); end
  endtask

  task automatic test_stall_tie();
    clear_tab();
    hit_tab[3] = 1; t_tab[3] = 32'h400;
    hit_tab[7] = 1; t_tab[7] = 32'h400;
    hit_tab[5] = 1; t_tab[5] = 32'h800;
    hit_tab[8] = 1; t_tab[8] = 32'h0;
    hit_tab[9] = 1; t_tab[9] = 32'hffff_ff00;
    scan(10, 4, 1, 0, -1, 0);
    checks++; if (v_stable !== 0)    begin failures++; $display("FAIL stall_idx_stable: got %0d errors expected 0", v_stable); end
    checks++; if (v_order + v_valid !== 0) begin failures++; $display("FAIL stall_issue: got %0d errors expected 0", v_order + v_valid); end
    checks++; if (fires !== 10)      begin failures++; $display("FAIL stall_issues: got %0d expected 10", fires); end
    checks++; if (hit_idx !== 10'd3) begin failures++; $display("FAIL stall_tie_idx: got %0d expected 3", hit_idx); end
    checks++; if (hit_t !== 32'h400) begin failures++; $display("FAIL stall_tie_t: got %0h expected 400", hit_t); end
    checks++; if (done_cnt !== 1)    begin failures++; $display("FAIL stall_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_tab();
    hit_tab[1] = 1; t_tab[1] = 32'h300;
    hit_tab[2] = 1; t_tab[2] = 32'h300;
    scan(3, 2, 0, 0, -1, 1);
    checks++; if (done_cyc !== 6)    begin failures++; $display("FAIL b2b_busy_start_latency: got %0d expected 6", done_cyc); end
    checks++; if (fires !== 3)       begin failures++; $display("FAIL b2b_busy_start_issues: got %0d expected 3", fires); end
    checks++; if (hit_idx !== 10'd1) begin failures++; $display("FAIL b2b_busy_start_idx: got %0d expected 1", hit_idx); end
    clear_tab();
    hit_tab[0] = 1; t_tab[0] = 32'h100;
    scan(2, 2, 0, 0, -1, 0);
    checks++; if (done_cyc !== 5)    begin failures++; $display("FAIL b2b_second_latency: got %0d expected 5", done_cyc); end
    checks++; if (hit_idx !== 10'd0 || hit_t !== 32'h100) begin failures++; $display("FAIL b2b_second_hit: got %0d/%0h expected 0/100", hit_idx, hit_t); end
  endtask

  task automatic test_reset_mid();
    clear_tab();
    hit_tab[1] = 1; t_tab[1] = 32'h200;
    scan(12, 3, 0, 0, 5, 0);
    checks++; if (aborted !== 1'b1)  begin failures++; $display("FAIL rstmid_reached_idx5: got %0b expected 1", aborted); end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || iss_valid !== 1'b0) begin failures++; $display("FAIL rstmid_idle: got busy=%0b iss_valid=%0b expected 0/0", busy, iss_valid); end
    checks++; if (hit_any !== 1'b0 || hit_idx !== 10'd0 || hit_t !== 32'd0) begin failures++; $display("FAIL rstmid_hit_cleared: got %0b/%0d/%0h expected 0/0/0", hit_any, hit_idx, hit_t); end
    res_valid = 1'b1; res_hit = 1'b1; res_t = 32'h10; res_idx = 10'd4;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || hit_any !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_stray_result: got done=%0b hit_any=%0b busy=%0b expected 0/0/0", done, hit_any, busy); end
    end
    res_valid = 1'b0;
    clear_tab();
    hit_tab[0] = 1; t_tab[0] = 32'h1400;
    hit_tab[1] = 1; t_tab[1] = 32'h800;
    hit_tab[2] = 1; t_tab[2] = 32'hc00;
    scan(4, 3, 0, 0, -1, 0);
    checks++; if (done_cyc !== 8 || v_valid !== 0) begin failures++; $display("FAIL rstmid_rescan: got done_cyc=%0d valid_err=%0d expected 8/0", done_cyc, v_valid); end
    checks++; if (hit_idx !== 10'd1) begin failures++; $display("FAIL rstmid_rescan_idx: got %0d expected 1", hit_idx); end
  endtask

`ifdef TRI_HIT_SCHED_ANY_HIT_EN
  task automatic test_any_hit();
    clear_tab();
    hit_tab[2] = 1; t_tab[2] = 32'h900;
    hit_tab[5] = 1; t_tab[5] = 32'h100;
    scan(16, 4, 0, 1, -1, 0);
    checks++; if (v_valid !== 0)     begin failures++; $display("FAIL anyhit_stop_issue: got %0d errors expected 0", v_valid); end
    checks++; if (fires !== 6)       begin failures++; $display("FAIL anyhit_issues: got %0d expected 6", fires); end
    checks++; if (done_cnt !== 1 || n_res !== fires) begin failures++; $display("FAIL anyhit_drain: got done=%0d res=%0d expected 1/%0d", done_cnt, n_res, fires); end
    checks++; if (hit_idx !== 10'd2 || hit_t !== 32'h900) begin failures++; $display("FAIL anyhit_result: got %0d/%0h expected 2/900", hit_idx, hit_t); end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; tri_count = '0; iss_ready = 1'b0;
    res_valid = 1'b0; res_hit = 1'b0; res_t = '0; res_idx = '0;
`ifdef TRI_HIT_SCHED_ANY_HIT_EN
    any_hit = 1'b0;
`endif
    test_reset();
    test_basic();
    test_zero();
    test_nonpositive();
    test_limit();
    test_stall_tie();
    test_back_to_back();
    test_reset_mid();
`ifdef TRI_HIT_SCHED_ANY_HIT_EN
    test_any_hit();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
